execute_cycle: RTL
==================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 interrupt  in  1  squash E-M register to NOP and abort any division.
REQ-003 pc_E, branch_target_E, a_E, b_E, rd2_E, instruction_E  in  32 each  D-E buffer operands: op1, op2 (imm-muxed), store data.
REQ-004 isRet_E, isSt_E, isWb_E, isBeq_E, isBgt_E, isUbranch_E, isLd_E, isCall_E, isIret_E  in  1 each  D-E control flags.
REQ-005 alusignals_E  in  5  ALU op code; RD_E  in  4  destination register.
REQ-006 flags_restore  in  2  {gt,eq} value restored on Iret.
REQ-007 isbranch_taken_E  out  1  redirect fetch; branch_pc_E  out  32  redirect target.
REQ-008 stall_E  out  1  E stage busy; upstream holds F/D and the D-E buffer.
REQ-009 flags_E  out  2  current {gt,eq} flags register.
REQ-010 pc_M, alu_result_M, op2_M, instruction_M  out  32 each; isSt_M, isLd_M, isWb_M, isCall_M  out  1 each; rd_M  out  4  E-M buffer.

Function
REQ-011 ALU op codes: 0 add, 1 sub, 2 mul (low 32 bits), 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not (~b), 9 mov (b), 10 lsl, 11 lsr, 12 asr; 13-31 produce 0.
REQ-012 Shift amount is b_E[4:0]; add/sub/mul wrap modulo 2^32.
REQ-013 div truncates toward zero (signed); mod takes the sign of the dividend; divisor 0 gives quotient 32'hFFFF_FFFF, remainder = a_E.
REQ-014 cmp updates the flags register at the clock edge: eq=(a_E==b_E), gt=(signed a_E > signed b_E); no other op writes the flags except Iret.
REQ-015 isIret_E loads flags_restore into the flags register; Iret wins over cmp if both are asserted.
REQ-016 isbranch_taken_E = isUbranch_E | (isBeq_E & eq) | (isBgt_E & gt), combinational, using registered flags (result of an earlier cmp).
REQ-017 branch_pc_E = a_E when isRet_E, else branch_target_E.
REQ-018 Call: alu_result_M = pc_E + 4, rd_M = 4'd15; otherwise rd_M = RD_E.
REQ-019 Single-cycle ops: E-M buffer loads on the next edge (latency 1); stall_E = 0.
REQ-020 interrupt has priority over everything but rst: E-M buffer gets a bubble (instruction_M = 32'h6800_0000 NOP, all control outputs 0, data 0) and the flags register is unchanged.
REQ-021 While stall_E = 1, the E-M buffer receives bubbles every cycle.

Reset
REQ-022 On rst the E-M buffer is zeroed and instruction_M = 32'h6800_0000; flags = 2'b00; divider FSM = IDLE; the counter is cleared.
REQ-023 rst during a division aborts it; stall_E = 0 in the following cycle.

Configuration
REQ-024 Macro EXEC_MULTICYCLE_DIV_EN defined: div/mod use an iterative divider FSM. States are IDLE, BUSY, DONE. IDLE->BUSY on div/mod (counter = 31). BUSY decrements; at counter 0 it goes to DONE. DONE latches the result into the E-M buffer and goes to IDLE.
REQ-025 With the macro defined, stall_E = 1 combinationally from the first cycle div/mod is presented through the final BUSY cycle (33 cycles); it is 0 in DONE. The operands are captured at IDLE->BUSY.
REQ-026 With the macro defined, interrupt in BUSY/DONE returns the FSM to IDLE, drops stall_E, and emits a bubble.
REQ-027 Macro undefined: div/mod are single-cycle combinational, stall_E is tied 0, there is no FSM, and REQ-013 still holds.

Structure
REQ-028 Shared package holds: ALU op-code constants, the NOP encoding, the flag bit indices, and the divider state enum.
REQ-029 One sub-module, seq_divider (signed restoring divider, start/busy/done handshake), is instantiated only under EXEC_MULTICYCLE_DIV_EN.

Verification
REQ-030 add a=32'h7FFF_FFFF, b=1 -> alu_result_M = 32'h8000_0000 one cycle later.
REQ-031 cmp a=-1, b=1, then beq and bgt -> flags = 2'b00, neither branch taken; cmp 5,5 then beq -> taken, branch_pc_E = branch_target_E.
REQ-032 div a=-7, b=2 (macro on) -> stall_E high 33 cycles, then alu_result_M = 32'hFFFF_FFFD; mod -> 32'hFFFF_FFFF; b=0 div -> 32'hFFFF_FFFF.
REQ-033 interrupt at BUSY cycle 10 -> stall_E = 0 next cycle, instruction_M = 32'h6800_0000, FSM IDLE.
REQ-034 call at pc_E = 32'h100 -> alu_result_M = 32'h104, rd_M = 15, isbranch_taken_E = 1; ret with a_E = 32'h104 -> branch_pc_E = 32'h104.
REQ-035 rst asserted mid-division and after a cmp -> all E-M outputs zero/NOP, flags 00, stall_E 0.

Source files
------------

// File: rtl/execute_cycle_pkg.sv
// execute_cycle_pkg: ALU op codes, NOP encoding, flag bit indices, divider states, E-M buffer type, signed div/mod helper
package execute_cycle_pkg;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_MUL = 5'd2, ALU_DIV = 5'd3, ALU_MOD = 5'd4,
                         ALU_CMP = 5'd5, ALU_AND = 5'd6, ALU_OR = 5'd7, ALU_NOT = 5'd8, ALU_MOV = 5'd9,
                         ALU_LSL = 5'd10, ALU_LSR = 5'd11, ALU_ASR = 5'd12;
  localparam logic [31:0] NOP = 32'h6800_0000;
  localparam int FLAG_EQ = 0, FLAG_GT = 1;
  localparam logic [3:0] RA_REG = 4'd15;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] op2;
    logic [31:0] instruction;
    logic        is_st;
    logic        is_ld;
    logic        is_wb;
    logic        is_call;
    logic [3:0]  rd;
  } em_t;
  localparam em_t EM_BUBBLE = '{pc: '0, alu_result: '0, op2: '0, instruction: NOP,
                                is_st: 1'b0, is_ld: 1'b0, is_wb: 1'b0, is_call: 1'b0, rd: '0};
  // {quotient, remainder}; magnitudes divided unsigned so -2^31 / -1 wraps instead of overflowing
  function automatic logic [63:0] sdivmod(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    if (b == '0) return {32'hFFFF_FFFF, a};
    q = ma / mb;
    r = ma % mb;
    return {(a[31] ^ b[31]) ? -q : q, a[31] ? -r : r};
  endfunction
endpackage

// File: rtl/execute_cycle_seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per BUSY cycle
//   in : clk, rst, start (IDLE only), abort (to IDLE), dividend, divisor
//   out: busy, done, quotient, remainder (valid in DONE; divisor 0 gives all-ones / dividend)
module seq_divider
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_e state_q;
  logic [4:0] cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q, dvd_q;
  logic [1:0] sgn_q;
  logic [32:0] shl;
  logic fits;
  assign shl = {rem_q, quo_q[31]};
  assign fits = shl >= {1'b0, dvs_q};
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: if (start) begin
          state_q <= DIV_BUSY;
          cnt_q <= 5'd31;
          rem_q <= '0;
          quo_q <= dividend[31] ? -dividend : dividend;
          dvs_q <= divisor[31] ? -divisor : divisor;
          dvd_q <= dividend;
          sgn_q <= {dividend[31] ^ divisor[31], dividend[31]};
        end
        DIV_BUSY: begin
          rem_q <= fits ? 32'(shl - {1'b0, dvs_q}) : shl[31:0];
          quo_q <= {quo_q[30:0], fits};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= DIV_DONE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end
  assign busy = state_q == DIV_BUSY;
  assign done = state_q == DIV_DONE;
  assign quotient = dvs_q == '0 ? '1 : sgn_q[1] ? -quo_q : quo_q;
  assign remainder = dvs_q == '0 ? dvd_q : sgn_q[0] ? -rem_q : rem_q;
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: pipeline E stage -- ALU, {gt,eq} flags, branch resolve, E-M buffer
//   in : clk, rst, interrupt, D-E buffer operands/flags, alusignals_E, RD_E, flags_restore
//   out: isbranch_taken_E, branch_pc_E, stall_E, flags_E, E-M buffer (*_M)
//   EXEC_MULTICYCLE_DIV_EN: div/mod run on seq_divider and stall the pipe; otherwise single-cycle
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt,
  input  logic [31:0] pc_E,
  input  logic [31:0] branch_target_E,
  input  logic [31:0] a_E,
  input  logic [31:0] b_E,
  input  logic [31:0] rd2_E,
  input  logic [31:0] instruction_E,
  input  logic        isRet_E,
  input  logic        isSt_E,
  input  logic        isWb_E,
  input  logic        isBeq_E,
  input  logic        isBgt_E,
  input  logic        isUbranch_E,
  input  logic        isLd_E,
  input  logic        isCall_E,
  input  logic        isIret_E,
  input  logic [4:0]  alusignals_E,
  input  logic [3:0]  RD_E,
  input  logic [1:0]  flags_restore,
  output logic        isbranch_taken_E,
  output logic [31:0] branch_pc_E,
  output logic        stall_E,
  output logic [1:0]  flags_E,
  output logic [31:0] pc_M,
  output logic [31:0] alu_result_M,
  output logic [31:0] op2_M,
  output logic [31:0] instruction_M,
  output logic        isSt_M,
  output logic        isLd_M,
  output logic        isWb_M,
  output logic        isCall_M,
  output logic [3:0]  rd_M
);
  em_t em_d, em_q;
  logic [1:0] flags_d, flags_q, cmp_flags;
  logic [31:0] alu_r, quo, rem;
  logic is_div;
  assign is_div = alusignals_E == ALU_DIV || alusignals_E == ALU_MOD;
`ifdef EXEC_MULTICYCLE_DIV_EN
  logic div_busy, div_done;
  seq_divider u_div (
    .clk(clk), .rst(rst),
    .start(is_div && !div_busy && !div_done && !interrupt), .abort(interrupt),
    .dividend(a_E), .divisor(b_E),
    .busy(div_busy), .done(div_done), .quotient(quo), .remainder(rem)
  );
  // stalled from the cycle div/mod is presented in IDLE until the last BUSY cycle
  assign stall_E = div_busy || (is_div && !div_done);
`else
  assign {quo, rem} = sdivmod(a_E, b_E);
  assign stall_E = 1'b0;
`endif
  assign cmp_flags[FLAG_GT] = $signed(a_E) > $signed(b_E);
  assign cmp_flags[FLAG_EQ] = a_E == b_E;
  always_comb begin
    case (alusignals_E)
      ALU_ADD: alu_r = a_E + b_E;
      ALU_SUB: alu_r = a_E - b_E;
      ALU_MUL: alu_r = a_E * b_E;
      ALU_DIV: alu_r = quo;
      ALU_MOD: alu_r = rem;
      ALU_AND: alu_r = a_E & b_E;
      ALU_OR:  alu_r = a_E | b_E;
      ALU_NOT: alu_r = ~b_E;
      ALU_MOV: alu_r = b_E;
      ALU_LSL: alu_r = a_E << b_E[4:0];
      ALU_LSR: alu_r = a_E >> b_E[4:0];
      ALU_ASR: alu_r = $signed(a_E) >>> b_E[4:0];
      default: alu_r = '0;
    endcase
  end
  always_comb begin
    em_d = (interrupt || stall_E) ? EM_BUBBLE :
           em_t'{pc: pc_E, alu_result: isCall_E ? pc_E + 32'd4 : alu_r, op2: rd2_E,
                 instruction: instruction_E, is_st: isSt_E, is_ld: isLd_E, is_wb: isWb_E,
                 is_call: isCall_E, rd: isCall_E ? RA_REG : RD_E};
    flags_d = interrupt ? flags_q : isIret_E ? flags_restore :
              alusignals_E == ALU_CMP ? cmp_flags : flags_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      em_q <= EM_BUBBLE;
      flags_q <= '0;
    end else begin
      em_q <= em_d;
      flags_q <= flags_d;
    end
  end
  assign isbranch_taken_E = isUbranch_E | (isBeq_E & flags_q[FLAG_EQ]) | (isBgt_E & flags_q[FLAG_GT]);
  assign branch_pc_E = isRet_E ? a_E : branch_target_E;
  assign flags_E = flags_q;
  assign pc_M = em_q.pc;
  assign alu_result_M = em_q.alu_result;
  assign op2_M = em_q.op2;
  assign instruction_M = em_q.instruction;
  assign isSt_M = em_q.is_st;
  assign isLd_M = em_q.is_ld;
  assign isWb_M = em_q.is_wb;
  assign isCall_M = em_q.is_call;
  assign rd_M = em_q.rd;
endmodule
